// File: rtl/tff_bank_pkg.sv
// tff_bank_pkg: shared mode encoding and the per-bit next-state function
// for the multimode flip-flop bank (tff_bank_multimode).
package tff_bank_pkg;

  // Runtime-selectable flip-flop behaviour, shared by every channel.
  typedef enum logic [1:0] {
    MODE_D  = 2'd0,
    MODE_T  = 2'd1,
    MODE_JK = 2'd2,
    MODE_SR = 2'd3
  } mode_e;

  // Next state of a single bit.
  //   a = D / T / J / S operand, b = K / R operand (unused in D and T).
  // SR with S=R=1 holds the bit; flagging that case is left to the caller.
  function automatic logic next_bit(input mode_e m, input logic q,
                                    input logic a, input logic b);
    logic nb;
    nb = q;
    case (m)
      MODE_D:  nb = a;
      MODE_T:  nb = q ^ a;
      MODE_JK: begin
        case ({a, b})
          2'b00:   nb = q;
          2'b01:   nb = 1'b0;
          2'b10:   nb = 1'b1;
          default: nb = ~q;
        endcase
      end
      MODE_SR: begin
        case ({a, b})
          2'b01:   nb = 1'b0;
          2'b10:   nb = 1'b1;
          default: nb = q;
        endcase
      end
      default: nb = q;
    endcase
    return nb;
  endfunction

endpackage : tff_bank_pkg

// File: rtl/tff_bank_sync.sv
// tff_bank_sync: WIDTH-bit two-flop synchroniser for the operand buses of
// tff_bank_multimode. Both stages reset to zero.
module tff_bank_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1_reg;
  logic [WIDTH-1:0] stage2_reg;

  // Two back-to-back flops; the second stage feeds the update logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1_reg <= '0;
      stage2_reg <= '0;
    end else begin
      stage1_reg <= d;
      stage2_reg <= stage1_reg;
    end
  end

  assign q = stage2_reg;

endmodule : tff_bank_sync

// File: rtl/tff_bank_multimode.sv
// tff_bank_multimode: bank of WIDTH flip-flop channels sharing one runtime
// mode (D, T, JK, SR), with clock enable, guarded mode writes, sticky
// SR-illegal flag and a saturating change-event counter.
// Optional build macro: INPUT_SYNC_EN -- passes a_in/b_in through a
// two-flop synchroniser (operand-to-q latency becomes 3 edges).
module tff_bank_multimode
  import tff_bank_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               CNT_W      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
  parameter logic [1:0]       RESET_MODE = 2'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode_we,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [1:0]       mode,
  output logic             chg,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             sr_err
);

  // Operands as seen by the update logic (direct or synchronised).
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;

  // State registers.
  logic [WIDTH-1:0] q_reg;
  mode_e            mode_reg;
  logic             chg_reg;
  logic [CNT_W-1:0] chg_cnt_reg;
  logic             sr_err_reg;
  logic             run_reg;

  // Next-state terms.
  logic [WIDTH-1:0] q_next;
  logic             changed;
  logic             sr_hit;
  logic             active_edge;
  logic             cnt_sat;

`ifdef INPUT_SYNC_EN
  tff_bank_sync #(.WIDTH(WIDTH)) u_sync_a (
    .clk (clk),
    .rst (rst),
    .d   (a_in),
    .q   (a_op)
  );

  tff_bank_sync #(.WIDTH(WIDTH)) u_sync_b (
    .clk (clk),
    .rst (rst),
    .d   (b_in),
    .q   (b_op)
  );
`else
  assign a_op = a_in;
  assign b_op = b_in;
`endif

  // Per-channel next state; all channels share the current mode.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    assign q_next[gi] = next_bit(mode_reg, q_reg[gi], a_op[gi], b_op[gi]);
  end

  assign changed     = (q_next != q_reg);
  assign sr_hit      = (mode_reg == MODE_SR) && (|(a_op & b_op));
  assign active_edge = run_reg && en && !mode_we;
  assign cnt_sat     = (chg_cnt_reg == {CNT_W{1'b1}});

  // Reset is applied asynchronously; the first edge after release only
  // arms run_reg so that no update happens on the releasing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  // Flip-flop state, mode register, change pulse and change counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg       <= RESET_VAL;
      mode_reg    <= mode_e'(RESET_MODE);
      chg_reg     <= 1'b0;
      chg_cnt_reg <= '0;
    end else if (run_reg) begin
      if (mode_we) begin
        // Mode writes take priority over en and hold q for that edge.
        mode_reg <= mode_e'(mode_in);
        chg_reg  <= 1'b0;
      end else if (en) begin
        q_reg   <= q_next;
        chg_reg <= changed;
        if (changed && !cnt_sat) begin
          chg_cnt_reg <= chg_cnt_reg + CNT_W'(1);
        end
      end else begin
        chg_reg <= 1'b0;
      end
    end
  end

  // Sticky S=R=1 flag; a new hit wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_err_reg <= 1'b0;
    end else if (run_reg) begin
      if (active_edge && sr_hit) begin
        sr_err_reg <= 1'b1;
      end else if (err_clr) begin
        sr_err_reg <= 1'b0;
      end
    end
  end

  assign q       = q_reg;
  assign q_n     = ~q_reg;
  assign mode    = mode_reg;
  assign chg     = chg_reg;
  assign chg_cnt = chg_cnt_reg;
  assign sr_err  = sr_err_reg;

endmodule : tff_bank_multimode

// File: tb/tb_tff_bank_multimode.sv
// tb_tff_bank_multimode: directed self-checking bench for tff_bank_multimode.
// A second instance with CNT_W=2 shares all inputs and is used for the
// counter-saturation scenario.
module tb_tff_bank_multimode;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode_we;
  logic [1:0] mode_in;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       err_clr;

  logic [7:0] q;
  logic [7:0] q_n;
  logic [1:0] mode;
  logic       chg;
  logic [7:0] chg_cnt;
  logic       sr_err;

  logic [7:0] s_q;
  logic [7:0] s_q_n;
  logic [1:0] s_mode;
  logic       s_chg;
  logic [1:0] s_chg_cnt;
  logic       s_sr_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  tff_bank_multimode #(.WIDTH(8), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode_we (mode_we),
    .mode_in (mode_in),
    .a_in    (a_in),
    .b_in    (b_in),
    .err_clr (err_clr),
    .q       (q),
    .q_n     (q_n),
    .mode    (mode),
    .chg     (chg),
    .chg_cnt (chg_cnt),
    .sr_err  (sr_err)
  );

  tff_bank_multimode #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode_we (mode_we),
    .mode_in (mode_in),
    .a_in    (a_in),
    .b_in    (b_in),
    .err_clr (err_clr),
    .q       (s_q),
    .q_n     (s_q_n),
    .mode    (s_mode),
    .chg     (s_chg),
    .chg_cnt (s_chg_cnt),
    .sr_err  (s_sr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 0; en = 0; mode_we = 0; mode_in = 2'd0;
    a_in = 8'h00; b_in = 8'h00; err_clr = 0;
    #1 rst = 1;
    #1;
    vec_cnt++;
    if (q !== 8'h00 || q_n !== 8'hFF || mode !== 2'd1 || chg !== 1'b0 ||
        chg_cnt !== 8'd0 || sr_err !== 1'b0) begin
      $display("FAIL reset_state: q=%h q_n=%h mode=%0d chg=%b cnt=%0d err=%b, expected q=00 q_n=ff mode=1 chg=0 cnt=0 err=0",
               q, q_n, mode, chg, chg_cnt, sr_err);
      err_cnt++;
    end
    en = 1; a_in = 8'h01;
    #2 rst = 0;
    step();
    vec_cnt++;
    if (q !== 8'h00 || chg !== 1'b0) begin
      $display("FAIL release_edge_no_update: q=%h chg=%b, expected q=00 chg=0", q, chg);
      err_cnt++;
    end
  endtask

  task automatic test_toggle();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h01; exp_q[1] = 8'h00; exp_q[2] = 8'h01; exp_q[3] = 8'h00;
    en = 1; a_in = 8'h01; b_in = 8'h00;
    for (int k = 0; k < 4; k++) begin
      step();
      vec_cnt++;
      if (q !== exp_q[k] || chg !== 1'b1 || chg_cnt !== 8'(k + 1)) begin
        $display("FAIL toggle_%0d: q=%h chg=%b cnt=%0d, expected q=%h chg=1 cnt=%0d",
                 k, q, chg, chg_cnt, exp_q[k], k + 1);
        err_cnt++;
      end
    end
  endtask

  task automatic test_mode_write();
    mode_we = 1; mode_in = 2'd0; a_in = 8'hA5;
    step();
    vec_cnt++;
    if (q !== 8'h00 || mode !== 2'd0 || chg !== 1'b0 || chg_cnt !== 8'd4) begin
      $display("FAIL mode_write_hold: q=%h mode=%0d chg=%b cnt=%0d, expected q=00 mode=0 chg=0 cnt=4",
               q, mode, chg, chg_cnt);
      err_cnt++;
    end
    mode_we = 0;
    step();
    vec_cnt++;
    if (q !== 8'hA5 || q_n !== 8'h5A || chg !== 1'b1 || chg_cnt !== 8'd5) begin
      $display("FAIL d_load: q=%h q_n=%h chg=%b cnt=%0d, expected q=a5 q_n=5a chg=1 cnt=5",
               q, q_n, chg, chg_cnt);
      err_cnt++;
    end
    // Writing the mode already in force still holds q for that edge.
    mode_we = 1; mode_in = 2'd0; a_in = 8'h5A;
    step();
    vec_cnt++;
    if (q !== 8'hA5 || mode !== 2'd0 || chg !== 1'b0) begin
      $display("FAIL same_mode_write_hold: q=%h mode=%0d chg=%b, expected q=a5 mode=0 chg=0",
               q, mode, chg);
      err_cnt++;
    end
    mode_we = 0;
    step();
    vec_cnt++;
    if (q !== 8'h5A || chg_cnt !== 8'd6) begin
      $display("FAIL d_load2: q=%h cnt=%0d, expected q=5a cnt=6", q, chg_cnt);
      err_cnt++;
    end
  endtask

  task automatic test_en_low();
    en = 0; a_in = 8'hFF;
    step();
    vec_cnt++;
    if (q !== 8'h5A || chg !== 1'b0 || chg_cnt !== 8'd6) begin
      $display("FAIL en_low_hold: q=%h chg=%b cnt=%0d, expected q=5a chg=0 cnt=6",
               q, chg, chg_cnt);
      err_cnt++;
    end
    en = 1;
  endtask

  task automatic test_jk();
    a_in = 8'h0F;
    step();
    mode_we = 1; mode_in = 2'd2;
    step();
    mode_we = 0; a_in = 8'hF0; b_in = 8'h3C;
    step();
    vec_cnt++;
    if (q !== 8'hF3 || mode !== 2'd2 || chg !== 1'b1 || chg_cnt !== 8'd8) begin
      $display("FAIL jk_update: q=%h mode=%0d chg=%b cnt=%0d, expected q=f3 mode=2 chg=1 cnt=8",
               q, mode, chg, chg_cnt);
      err_cnt++;
    end
  endtask

  task automatic test_sr();
    mode_we = 1; mode_in = 2'd3; a_in = 8'h00; b_in = 8'h00;
    step();
    mode_we = 0; a_in = 8'h01; b_in = 8'h01;
    step();
    vec_cnt++;
    if (q !== 8'hF3 || sr_err !== 1'b1 || chg !== 1'b0) begin
      $display("FAIL sr_illegal: q=%h sr_err=%b chg=%b, expected q=f3 sr_err=1 chg=0",
               q, sr_err, chg);
      err_cnt++;
    end
    err_clr = 1; a_in = 8'h00; b_in = 8'h00;
    step();
    vec_cnt++;
    if (sr_err !== 1'b0) begin
      $display("FAIL sr_clear: sr_err=%b, expected 0", sr_err);
      err_cnt++;
    end
    a_in = 8'h01; b_in = 8'h01;
    step();
    vec_cnt++;
    if (sr_err !== 1'b1 || q !== 8'hF3) begin
      $display("FAIL sr_set_beats_clear: sr_err=%b q=%h, expected sr_err=1 q=f3", sr_err, q);
      err_cnt++;
    end
    err_clr = 0; a_in = 8'h04; b_in = 8'h02;
    step();
    vec_cnt++;
    if (q !== 8'hF5 || sr_err !== 1'b1 || chg_cnt !== 8'd9) begin
      $display("FAIL sr_set_reset: q=%h sr_err=%b cnt=%0d, expected q=f5 sr_err=1 cnt=9",
               q, sr_err, chg_cnt);
      err_cnt++;
    end
    err_clr = 1; a_in = 8'h00; b_in = 8'h00;
    step();
    err_clr = 0;
    vec_cnt++;
    if (sr_err !== 1'b0 || q !== 8'hF5) begin
      $display("FAIL sr_hold_clear: sr_err=%b q=%h, expected sr_err=0 q=f5", sr_err, q);
      err_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vecs [5];
    logic [7:0] prev;
    int         exp_cnt;
    vecs[0] = 8'h3C; vecs[1] = 8'h3C; vecs[2] = 8'hC3; vecs[3] = 8'h00; vecs[4] = 8'hFF;
    mode_we = 1; mode_in = 2'd0;
    step();
    mode_we = 0;
    prev    = 8'hF5;
    exp_cnt = 9;
    for (int k = 0; k < 5; k++) begin
      a_in = vecs[k];
      step();
      if (vecs[k] != prev) exp_cnt++;
      vec_cnt++;
      if (q !== vecs[k] || chg !== (vecs[k] != prev) || chg_cnt !== 8'(exp_cnt)) begin
        $display("FAIL b2b_%0d: q=%h chg=%b cnt=%0d, expected q=%h chg=%b cnt=%0d",
                 k, q, chg, chg_cnt, vecs[k], (vecs[k] != prev), exp_cnt);
        err_cnt++;
      end
      prev = vecs[k];
    end
  endtask

  task automatic test_saturate();
    logic [7:0] exp_q;
    int         exp_small;
    rst = 1;
    #1;
    en = 1; mode_we = 0; a_in = 8'h01; b_in = 8'h00; err_clr = 0;
    vec_cnt++;
    if (s_q !== 8'h00 || s_mode !== 2'd1 || s_chg_cnt !== 2'd0) begin
      $display("FAIL sat_reset: q=%h mode=%0d cnt=%0d, expected q=00 mode=1 cnt=0",
               s_q, s_mode, s_chg_cnt);
      err_cnt++;
    end
    #2 rst = 0;
    step();
    exp_q = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_q     = exp_q ^ 8'h01;
      exp_small = (k > 3) ? 3 : k;
      vec_cnt++;
      if (s_q !== exp_q || s_chg !== 1'b1 || s_chg_cnt !== 2'(exp_small) ||
          chg_cnt !== 8'(k)) begin
        $display("FAIL saturate_%0d: q=%h chg=%b cnt2=%0d cnt8=%0d, expected q=%h chg=1 cnt2=%0d cnt8=%0d",
                 k, s_q, s_chg, s_chg_cnt, chg_cnt, exp_q, exp_small, k);
        err_cnt++;
      end
    end
    // Mid-cycle asynchronous reset: outputs must clear without an edge.
    #2 rst = 1;
    #1;
    vec_cnt++;
    if (q !== 8'h00 || q_n !== 8'hFF || mode !== 2'd1 || chg !== 1'b0 ||
        chg_cnt !== 8'd0 || sr_err !== 1'b0 || s_q !== 8'h00 || s_chg !== 1'b0 ||
        s_chg_cnt !== 2'd0) begin
      $display("FAIL async_reset: q=%h q_n=%h mode=%0d chg=%b cnt=%0d err=%b sq=%h schg=%b scnt=%0d, expected all cleared",
               q, q_n, mode, chg, chg_cnt, sr_err, s_q, s_chg, s_chg_cnt);
      err_cnt++;
    end
    #4 rst = 0;
    step();
  endtask

  task automatic test_sync();
    mode_we = 1; mode_in = 2'd0;
    step();
    mode_we = 0; en = 1; a_in = 8'h00;
    step(); step(); step();
    vec_cnt++;
    if (q !== 8'h00) begin
      $display("FAIL sync_settle: q=%h, expected 00", q);
      err_cnt++;
    end
    a_in = 8'hFF;
    for (int k = 1; k <= 3; k++) begin
      step();
      vec_cnt++;
      if (q !== ((k == 3) ? 8'hFF : 8'h00)) begin
        $display("FAIL sync_latency_%0d: q=%h, expected %h", k, q, (k == 3) ? 8'hFF : 8'h00);
        err_cnt++;
      end
    end
    a_in = 8'h00; en = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      vec_cnt++;
      if (q !== 8'hFF) begin
        $display("FAIL sync_en_low_%0d: q=%h, expected ff", k, q);
        err_cnt++;
      end
    end
    en = 1;
    step();
    vec_cnt++;
    if (q !== 8'h00) begin
      $display("FAIL sync_after_en: q=%h, expected 00", q);
      err_cnt++;
    end
  endtask

  initial begin
    test_reset();
`ifdef INPUT_SYNC_EN
    test_sync();
`else
    test_toggle();
    test_mode_write();
    test_en_low();
    test_jk();
    test_sr();
    test_back_to_back();
    test_saturate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_tff_bank_multimode
